cdc_handshake_tx: RTL and testbench
===================================

# cdc_handshake_tx

Source-domain end of a four-phase req/ack bundled-data clock-domain crossing. It accepts one word per transfer from local logic through a valid/ready handshake and drives `req` plus a stable data bus to a receiver in an unrelated clock domain. The receiver's `ack` is asynchronous, so the block passes it through an internal multi-flop synchronizer before its FSM uses it. It is used wherever a local-domain result must reach logic clocked by a different oscillator.

## Interface
- `WIDTH`, 8: width of the transferred data word.
- `SYNC_STAGES`, 2: number of flops in the `ack` synchronizer chain; minimum 2.
- `TIMEOUT`, 0: cycles to wait on either `ack` edge before flagging an error; 0 disables the timeout.

Ports:
- `clock`  in  1: source-domain clock; every flop is updated on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: local producer offers `in_data`.
- `in_data`  in  WIDTH: word to transfer.
- `in_ready`  out  1: block can accept a word this cycle.
- `req`  out  1: four-phase request to the far domain; driven directly from a flop.
- `out_data`  out  WIDTH: bundled data; driven directly from flops.
- `ack`  in  1: asynchronous acknowledge from the far domain.
- `done`  out  1: one-cycle pulse when a transfer fully completes.
- `timeout`  out  1: sticky error flag.

## Operation
- The `ack` synchronizer is a chain of `SYNC_STAGES` flops, all reset to 0. `ack_s` is the output of the last flop.
- FSM states are SETTLE, IDLE, REQ and REL. Reset state is SETTLE.
- **SETTLE:**
  - A counter counts `SYNC_STAGES` cycles so that the synchronizer reflects the true far-side `ack`.
  - The FSM then moves to REL.
  - This handles a reset that occurs while the far side is still holding `ack` high.
- **REL → IDLE:** taken when `ack_s == 0`. `done` pulses only when REL was entered from REQ, not when it was entered from SETTLE.
- **IDLE:**
  - `in_ready = 1`.
  - When `in_valid && in_ready` at a clock edge: `out_data <= in_data`, `req <= 1`, next state REQ.
- **REQ → REL:** taken when `ack_s == 1`; at that edge `req <= 0`.
- **`in_ready`:** equals 1 only in IDLE; it is decoded combinationally from the state.
- **`out_data` stability:** `out_data` is loaded only on acceptance. It holds through REQ and REL and after completion, until the next acceptance.
- **Timeout counter:**
  - Active only when `TIMEOUT > 0`.
  - Clears on every state change and increments every cycle spent in REQ or REL.
  - When it reaches `TIMEOUT`, `timeout <= 1`, the counter saturates, and the FSM keeps waiting; there is no abort.
  - `timeout` is cleared only by `reset`.
- **Mid-transfer `ack` glitches:** an `ack_s` fall while in REQ, or an `ack_s` rise while in REL, is ignored. The FSM reacts only to the level it is waiting for.
- **`in_valid` outside IDLE:** ignored, with no buffering. The producer must hold its word until `in_ready` is high.

## Timing
- **Reset values:** `req = 0`, `out_data = 0`, `in_ready = 0`, `done = 0`, `timeout = 0`, all synchronizer flops = 0, state SETTLE.
- **After reset deassert:** `in_ready` rises after `SYNC_STAGES + 1` cycles if `ack` is low. Otherwise it rises once `ack` falls, after synchronizer latency.
- **Acceptance to request:** acceptance at edge N makes `req = 1` and the new `out_data` visible after edge N. Both change on the same edge.
- **`ack` to `req` release:** if `ack` rises and is stable before edge M, `ack_s` is high after edge M+`SYNC_STAGES`−1, and `req` falls after edge M+`SYNC_STAGES`.
- **`ack` fall to completion:** `ack` falling stable before edge K makes `ack_s` low after edge K+`SYNC_STAGES`−1. After edge K+`SYNC_STAGES`, the state is IDLE, `in_ready = 1` and `done = 1`, each for that cycle onward; `done` is high for exactly one cycle.
- **Back-to-back transfers:** a new acceptance may occur in the same cycle `done` is high.
- **Minimum transfer time with instant far-side response:** 2·`SYNC_STAGES` + 2 cycles from acceptance to next `in_ready`.
- **Reset mid-operation:** `req` and `out_data` drop to 0 on the reset edge, and `done` is not asserted.

## Test plan
- **Single transfer:** `WIDTH=8`, `SYNC_STAGES=2`, `in_data=0xA5`, and a model receiver that raises `ack` 3 cycles after seeing `req` and drops it 3 cycles after `req` falls. Required: `out_data=0xA5` with `req` high one cycle after acceptance; `req` falls 2 edges after `ack` rises; exactly one `done` pulse; `out_data` is still 0xA5 afterward.
- **Back-to-back:** `in_valid` held high with words 0x01, 0x02, 0x03. Required: three `done` pulses, and `out_data` sequence 0x01, 0x02, 0x03 each stable for the whole `req`-high plus REL window. `in_valid` is never accepted while `in_ready=0`.
- **Reset with `ack` high:** assert `reset` while in REQ with `ack=1`, and keep `ack=1` for 10 cycles after reset. Required: `req=0` and `out_data=0` immediately; `in_ready` stays 0 until 3 cycles after `ack` falls; no `done` pulse.
- **Timeout:** `TIMEOUT=16` and `ack` tied 0 after acceptance. Required: `timeout` rises exactly 16 cycles after entering REQ and `req` stays 1. Raising `ack` then completes the transfer normally with `timeout` still 1.
- **Glitch immunity:** in REQ, pulse `ack` high for one cycle, shorter than the synchronizer passes; then apply a real `ack`. Required: either a clean completion or no premature `req` fall; `done` never pulses twice for one transfer.
- **Ignored `in_valid`:** drive `in_valid=1` with a changing `in_data` during REQ and REL. Required: `out_data` is unchanged until the next IDLE acceptance.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx
// Source-domain end of a four-phase req/ack bundled-data crossing. A word is
// accepted through valid/ready, held on out_data, and announced with req. The
// asynchronous ack is synchronized before the FSM looks at it.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// SETTLE | after reset, let the ack synchronizer fill with the true far level
// IDLE   | in_ready high, waiting for a word
// REQ    | req high, waiting for synchronized ack to rise
// REL    | req low, waiting for synchronized ack to fall
module cdc_handshake_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             req,
  output logic [WIDTH-1:0] out_data,
  input  logic             ack,
  output logic             done,
  output logic             timeout
);

  typedef enum logic [1:0] {SETTLE, IDLE, REQ, REL} state_t;

  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SYNC_STAGES - 1);

  state_t                 state;
  logic                   from_req;
  logic [SW-1:0]          settle_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;

  // Multi-flop synchronizer for the far-domain acknowledge.
  always_ff @(posedge clock) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], ack};
  end

  assign ack_s    = sync_q[SYNC_STAGES-1];
  assign in_ready = (state == IDLE);

  // Handshake FSM with registered req, out_data and done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      from_req   <= 1'b0;
      req        <= 1'b0;
      out_data   <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            // Pass through REL so a far side still holding ack is drained first.
            state    <= REL;
            from_req <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (in_valid) begin
            out_data <= in_data;
            req      <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            req      <= 1'b0;
            from_req <= 1'b1;
            state    <= REL;
          end
        end
        REL: begin
          if (!ack_s) begin
            done  <= from_req;
            state <= IDLE;
          end
        end
        default: state <= SETTLE;
      endcase
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int TW = $clog2(TIMEOUT + 1);
      localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
      localparam logic [TW-1:0] TO_FULL = TW'(TIMEOUT);

      logic [TW-1:0] to_cnt;
      logic          leave;
      logic          waiting;

      // Any state change restarts the wait measurement.
      always_comb begin
        leave = 1'b0;
        case (state)
          SETTLE:  leave = (settle_cnt == SETTLE_LAST);
          IDLE:    leave = in_valid;
          REQ:     leave = ack_s;
          REL:     leave = !ack_s;
          default: leave = 1'b1;
        endcase
      end

      assign waiting = (state == REQ) || (state == REL);

      // Saturating wait counter; the flag is sticky and never aborts the transfer.
      always_ff @(posedge clock) begin
        if (reset) begin
          to_cnt  <= '0;
          timeout <= 1'b0;
        end else if (leave) begin
          to_cnt <= '0;
        end else if (waiting) begin
          if (to_cnt == TO_LAST) timeout <= 1'b1;
          if (to_cnt != TO_FULL) to_cnt <= to_cnt + 1'b1;
        end
      end
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: one instance without timeout, one with
// TIMEOUT=16. Outputs are sampled 1 ns after each rising edge.
module tb_cdc_handshake_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid, ack;
  logic [7:0] in_data;
  logic       in_ready, req, done, timeout;
  logic [7:0] out_data;

  logic       in_valid_t, ack_t;
  logic [7:0] in_data_t;
  logic       in_ready_t, req_t, done_t, timeout_t;
  logic [7:0] out_data_t;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  logic [7:0] words [3];

  always #5 clock = ~clock;

  cdc_handshake_tx #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT(0)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .req(req), .out_data(out_data), .ack(ack),
    .done(done), .timeout(timeout)
  );

  cdc_handshake_tx #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT(16)) dut_t (
    .clock(clock), .reset(reset), .in_valid(in_valid_t), .in_data(in_data_t),
    .in_ready(in_ready_t), .req(req_t), .out_data(out_data_t), .ack(ack_t),
    .done(done_t), .timeout(timeout_t)
  );

  // Count done pulses of the main instance.
  always @(negedge clock) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; ack = 1'b0;
    in_valid_t = 1'b0; in_data_t = 8'h00; ack_t = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_req", 32'(req), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_timeout", 32'(timeout), 0);
    reset = 1'b0;
    tick(); chk("settle_ready1", 32'(in_ready), 0);
    tick(); chk("settle_ready2", 32'(in_ready), 0);
    tick(); chk("settle_ready3", 32'(in_ready), 1);
    chk("settle_nodone", 32'(done), 0);

    // Single transfer with a 3-cycle receiver
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    chk("s_req", 32'(req), 1);
    chk("s_data", 32'(out_data), 'hA5);
    chk("s_ready", 32'(in_ready), 0);
    in_valid = 1'b0; in_data = 8'h11;
    tick(); chk("s_req_n1", 32'(req), 1);
    tick(); chk("s_req_n2", 32'(req), 1);
    ack = 1'b1;
    tick(); chk("s_req_m0", 32'(req), 1);
    tick(); chk("s_req_m1", 32'(req), 1);
    tick(); chk("s_req_m2", 32'(req), 0);
    chk("s_data_rel", 32'(out_data), 'hA5);
    tick(); tick();
    ack = 1'b0;
    tick(); chk("s_ready_k0", 32'(in_ready), 0); chk("s_done_k0", 32'(done), 0);
    tick(); chk("s_ready_k1", 32'(in_ready), 0);
    tick(); chk("s_ready_k2", 32'(in_ready), 1); chk("s_done_k2", 32'(done), 1);
    chk("s_data_end", 32'(out_data), 'hA5);
    tick(); chk("s_done_k3", 32'(done), 0);

    // Back-to-back with an instant receiver and in_data churn mid-transfer
    in_valid = 1'b1; in_data = words[0];
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 7; k++) begin
        tick();
        ack = req;
        chk($sformatf("b2b_req_w%0d_k%0d", w, k), 32'(req), 32'(k < 3));
        chk($sformatf("b2b_data_w%0d_k%0d", w, k), 32'(out_data), 32'(w + 1));
        chk($sformatf("b2b_done_w%0d_k%0d", w, k), 32'(done), 32'(k == 6));
        chk($sformatf("b2b_ready_w%0d_k%0d", w, k), 32'(in_ready), 32'(k == 6));
        if (k < 6)      in_data = 8'hF0 + 8'(k);
        else if (w < 2) in_data = words[w + 1];
        else            in_valid = 1'b0;
      end
    end

    // Sub-cycle ack glitch in REQ, then a real ack
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    chk("g_req", 32'(req), 1);
    in_valid = 1'b0;
    ack = 1'b1; #3; ack = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick(); chk($sformatf("g_req_hold%0d", i), 32'(req), 1);
    end
    ack = 1'b1;
    tick(); chk("g_req_m0", 32'(req), 1);
    tick(); chk("g_req_m1", 32'(req), 1);
    tick(); chk("g_req_m2", 32'(req), 0);
    ack = 1'b0;
    tick(); chk("g_ready_k0", 32'(in_ready), 0);
    tick(); chk("g_ready_k1", 32'(in_ready), 0);
    tick(); chk("g_ready_k2", 32'(in_ready), 1);
    chk("g_done", 32'(done), 1);
    chk("g_data", 32'(out_data), 'h3C);

    // Reset in REQ while the far side holds ack high
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    chk("r_data_pre", 32'(out_data), 'h5A);
    in_valid = 1'b0; ack = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("r_req", 32'(req), 0);
    chk("r_data", 32'(out_data), 0);
    chk("r_ready", 32'(in_ready), 0);
    chk("r_done", 32'(done), 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("r_hold_ready%0d", i), 32'(in_ready), 0);
      chk($sformatf("r_hold_done%0d", i), 32'(done), 0);
    end
    ack = 1'b0;
    tick(); chk("r_ready_k0", 32'(in_ready), 0);
    tick(); chk("r_ready_k1", 32'(in_ready), 0);
    tick(); chk("r_ready_k2", 32'(in_ready), 1);
    chk("r_done_k2", 32'(done), 0);
    tick(); chk("r_done_k3", 32'(done), 0);
    chk("done_total", 32'(done_cnt), 5);
    chk("no_timeout", 32'(timeout), 0);

    // Timeout instance: ack held low after acceptance
    chk("t_ready", 32'(in_ready_t), 1);
    in_valid_t = 1'b1; in_data_t = 8'h77;
    tick();
    chk("t_req", 32'(req_t), 1);
    chk("t_data", 32'(out_data_t), 'h77);
    in_valid_t = 1'b0;
    repeat (14) tick();
    tick(); chk("t_flag_15", 32'(timeout_t), 0);
    tick(); chk("t_flag_16", 32'(timeout_t), 1); chk("t_req_16", 32'(req_t), 1);
    repeat (4) tick();
    chk("t_flag_20", 32'(timeout_t), 1); chk("t_req_20", 32'(req_t), 1);
    ack_t = 1'b1;
    tick(); tick();
    tick(); chk("t_req_rel", 32'(req_t), 0);
    ack_t = 1'b0;
    tick(); tick();
    tick();
    chk("t_done", 32'(done_t), 1);
    chk("t_ready_end", 32'(in_ready_t), 1);
    chk("t_flag_end", 32'(timeout_t), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
